// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Definitions shared by the score controller and all note-lane blocks.
//   - gamestate_e : encoding of the shared gamestate bus (00 is never driven)
//   - STREAK_W    : width of the hit-streak counter
//   - TIME_W      : width of the seconds-remaining counter
//   - MULT_W      : width of the score multiplier
//   - MULT_T2/3/4 : streak thresholds for multiplier 2, 3 and 4
//   - mult_from_streak() : streak -> multiplier mapping
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    GS_TITLE = 2'b01,
    GS_PLAY  = 2'b10,
    GS_OVER  = 2'b11
  } gamestate_e;

  localparam int STREAK_W = 8;
  localparam int TIME_W   = 7;
  localparam int MULT_W   = 3;

  localparam int MULT_T2 = 10;
  localparam int MULT_T3 = 20;
  localparam int MULT_T4 = 30;

  function automatic logic [MULT_W-1:0] mult_from_streak(input logic [STREAK_W-1:0] s);
    logic [MULT_W-1:0] m;
    if (int'(s) >= MULT_T4) begin
      m = MULT_W'(4);
    end else if (int'(s) >= MULT_T3) begin
      m = MULT_W'(3);
    end else if (int'(s) >= MULT_T2) begin
      m = MULT_W'(2);
    end else begin
      m = MULT_W'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/round_timer.sv
// -----------------------------------------------------------------------------
// round_timer
// Round countdown: a prescaler divides clk down to one-second ticks and a
// seconds counter counts down from ROUND_SECONDS.
//
// Ports:
//   clk          input   system clock
//   rst_ni       input   synchronous active-low reset
//   load_i       input   restart the round: prescaler=0, time_left=ROUND_SECONDS
//   enable_i     input   count this cycle (prescaler holds while low)
//   time_left_o  output  seconds remaining
//   expire_o     output  combinational, high during the single cycle whose
//                        clock edge takes time_left from 1 to 0
// -----------------------------------------------------------------------------
module round_timer
  import game_pkg::*;
#(
  parameter int TICK_DIV      = 100000000,
  parameter int ROUND_SECONDS = 60
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              enable_i,
  output logic [TIME_W-1:0] time_left_o,
  output logic              expire_o
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic               wrap;

  // The wrap cycle is the last prescaler cycle of each second.
  assign wrap        = enable_i && (presc_q == PRESC_LAST);
  assign expire_o    = wrap && (time_q == TIME_W'(1));
  assign time_left_o = time_q;

  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    if (load_i) begin
      presc_d = '0;
      time_d  = TIME_W'(ROUND_SECONDS);
    end else if (enable_i) begin
      if (wrap) begin
        presc_d = '0;
        // Never wraps below zero even if the owner keeps us enabled.
        if (time_q != '0) begin
          time_d = time_q - TIME_W'(1);
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      presc_q <= '0;
      time_q  <= TIME_W'(ROUND_SECONDS);
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
    end
  end

endmodule

// File: rtl/score_controller.sv
// -----------------------------------------------------------------------------
// score_controller
// Central game controller: sequences TITLE -> PLAY -> OVER -> TITLE, drives
// the shared gamestate bus, and turns per-lane hit/miss pulses into score,
// streak and multiplier. Also keeps the round timer and the high score.
//
// Ports:
//   clk          input   system clock
//   resetbtn_n   input   synchronous active-low reset (priority over all)
//   start_btn    input   single-cycle start/continue pulse
//   hit_pulse    input   [NUM_LANES] one-cycle point-scored pulses
//   miss_pulse   input   [NUM_LANES] one-cycle missed-press pulses
//   gamestate    output  01 TITLE, 10 PLAY, 11 OVER
//   score        output  [SCORE_W] current round score (saturating)
//   high_score   output  [SCORE_W] best round score since reset
//   streak       output  [8] consecutive hits without a miss (saturating)
//   multiplier   output  [3] 1..4, derived from streak
//   time_left    output  [7] seconds remaining in the round
//   new_high     output  high in OVER when this round beat the high score
//
// SCORE_W must be at most 32 (score arithmetic is done in 33 bits).
// -----------------------------------------------------------------------------
module score_controller
  import game_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int SCORE_W        = 16,
  parameter int POINTS_PER_HIT = 10,
  parameter int TICK_DIV       = 100000000,
  parameter int ROUND_SECONDS  = 60
) (
  input  logic                 clk,
  input  logic                 resetbtn_n,
  input  logic                 start_btn,
  input  logic [NUM_LANES-1:0] hit_pulse,
  input  logic [NUM_LANES-1:0] miss_pulse,
  output logic [1:0]           gamestate,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   high_score,
  output logic [STREAK_W-1:0]  streak,
  output logic [MULT_W-1:0]    multiplier,
  output logic [TIME_W-1:0]    time_left,
  output logic                 new_high
);

  localparam int CNT_W = $clog2(NUM_LANES + 1);
  localparam logic [32:0] SCORE_MAX = (33'd1 << SCORE_W) - 33'd1;

  // ---------------------------------------------------------------------------
  // Game-phase FSM
  // ---------------------------------------------------------------------------
  gamestate_e state_q, state_d;

  logic timer_expire;
  logic round_start;   // TITLE -> PLAY edge
  logic playing;       // scoring and timer active
  logic round_end;     // PLAY -> OVER edge
  logic leave_over;    // OVER -> TITLE edge

  always_ff @(posedge clk) begin
    if (!resetbtn_n) begin
      state_q <= GS_TITLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GS_TITLE: if (start_btn)    state_d = GS_PLAY;
      GS_PLAY:  if (timer_expire) state_d = GS_OVER;
      GS_OVER:  if (start_btn)    state_d = GS_TITLE;
      default:                    state_d = GS_TITLE;
    endcase
  end

  always_comb begin
    round_start = 1'b0;
    playing     = 1'b0;
    round_end   = 1'b0;
    leave_over  = 1'b0;
    unique case (state_q)
      GS_TITLE: round_start = start_btn;
      GS_PLAY: begin
        playing   = 1'b1;
        round_end = timer_expire;
      end
      GS_OVER:  leave_over = start_btn;
      default: ;
    endcase
  end

  assign gamestate = state_q;

  // ---------------------------------------------------------------------------
  // Round timer
  // ---------------------------------------------------------------------------
  round_timer #(
    .TICK_DIV      (TICK_DIV),
    .ROUND_SECONDS (ROUND_SECONDS)
  ) u_round_timer (
    .clk         (clk),
    .rst_ni      (resetbtn_n),
    .load_i      (round_start),
    .enable_i    (playing),
    .time_left_o (time_left),
    .expire_o    (timer_expire)
  );

  // ---------------------------------------------------------------------------
  // Scoring datapath
  // ---------------------------------------------------------------------------
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [MULT_W-1:0]   mult_q, mult_d;
  logic                new_high_q, new_high_d;

  logic [CNT_W-1:0]    hit_count;
  logic [31:0]         add_pts;
  logic [32:0]         sum_full;
  logic [SCORE_W-1:0]  score_next;
  logic [STREAK_W:0]   streak_sum;
  logic [STREAK_W-1:0] streak_next;

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit_count = hit_count + CNT_W'(hit_pulse[i]);
    end
  end

  // Points use the multiplier already registered, not the one this cycle's
  // hits will produce.
  assign add_pts    = 32'(hit_count) * 32'(mult_q) * 32'(POINTS_PER_HIT);
  assign sum_full   = 33'(score_q) + 33'(add_pts);
  assign score_next = (sum_full > SCORE_MAX) ? '1 : sum_full[SCORE_W-1:0];

  // A miss in the cycle wins over any simultaneous hits for the streak.
  assign streak_sum  = {1'b0, streak_q} + (STREAK_W + 1)'(hit_count);
  assign streak_next = (|miss_pulse)          ? '0 :
                       streak_sum[STREAK_W]   ? '1 :
                                                streak_sum[STREAK_W-1:0];

  always_comb begin
    score_d    = score_q;
    high_d     = high_q;
    streak_d   = streak_q;
    mult_d     = mult_q;
    new_high_d = new_high_q;
    if (round_start) begin
      score_d    = '0;
      streak_d   = '0;
      mult_d     = MULT_W'(1);
      new_high_d = 1'b0;
    end else if (playing) begin
      score_d  = score_next;
      streak_d = streak_next;
      mult_d   = mult_from_streak(streak_next);
      // Hits landing in the expiry cycle count toward the final score.
      if (round_end && (score_next > high_q)) begin
        high_d     = score_next;
        new_high_d = 1'b1;
      end
    end else if (leave_over) begin
      new_high_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetbtn_n) begin
      score_q    <= '0;
      high_q     <= '0;
      streak_q   <= '0;
      mult_q     <= MULT_W'(1);
      new_high_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      high_q     <= high_d;
      streak_q   <= streak_d;
      mult_q     <= mult_d;
      new_high_q <= new_high_d;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign streak     = streak_q;
  assign multiplier = mult_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_score_controller.sv
// -----------------------------------------------------------------------------
// tb_score_controller
// Directed bench for score_controller with TICK_DIV=4, ROUND_SECONDS=3 and an
// 8-bit score so that saturation is reachable within one short round.
// Each step drives inputs on the falling edge, advances a reference model and
// queues the expected outputs; after the rising edge the oldest expectation is
// popped and compared with the DUT.
// -----------------------------------------------------------------------------
module tb_score_controller;

  localparam int NL   = 4;
  localparam int SW   = 8;
  localparam int PPH  = 10;
  localparam int TD   = 4;
  localparam int RS   = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          resetbtn_n = 1'b0;
  logic          start_btn = 1'b0;
  logic [NL-1:0] hit_pulse = '0;
  logic [NL-1:0] miss_pulse = '0;
  logic [1:0]    gamestate;
  logic [SW-1:0] score;
  logic [SW-1:0] high_score;
  logic [7:0]    streak;
  logic [2:0]    multiplier;
  logic [6:0]    time_left;
  logic          new_high;

  always #5 clk = ~clk;

  score_controller #(
    .NUM_LANES      (NL),
    .SCORE_W        (SW),
    .POINTS_PER_HIT (PPH),
    .TICK_DIV       (TD),
    .ROUND_SECONDS  (RS)
  ) dut (
    .clk        (clk),
    .resetbtn_n (resetbtn_n),
    .start_btn  (start_btn),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .gamestate  (gamestate),
    .score      (score),
    .high_score (high_score),
    .streak     (streak),
    .multiplier (multiplier),
    .time_left  (time_left),
    .new_high   (new_high)
  );

  typedef struct packed {
    logic [1:0]    gs;
    logic [SW-1:0] sc;
    logic [SW-1:0] hi;
    logic [7:0]    st;
    logic [2:0]    mu;
    logic [6:0]    tl;
    logic          nh;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  int m_gs = 1, m_score = 0, m_high = 0, m_streak = 0;
  int m_mult = 1, m_tl = RS, m_nh = 0, m_presc = 0;

  task automatic model_step(input bit rst_n, input bit st, input bit [NL-1:0] hit,
                            input bit [NL-1:0] miss);
    int h, ns, nst;
    if (!rst_n) begin
      m_gs = 1; m_score = 0; m_high = 0; m_streak = 0;
      m_mult = 1; m_tl = RS; m_nh = 0; m_presc = 0;
      return;
    end
    case (m_gs)
      1: if (st) begin
        m_gs = 2; m_score = 0; m_streak = 0; m_mult = 1;
        m_tl = RS; m_presc = 0; m_nh = 0;
      end
      2: begin
        h  = $countones(hit);
        ns = m_score + h * m_mult * PPH;
        if (ns > SMAX) ns = SMAX;
        if (miss != 0) nst = 0;
        else begin
          nst = m_streak + h;
          if (nst > 255) nst = 255;
        end
        m_score  = ns;
        m_streak = nst;
        m_mult   = (nst >= 30) ? 4 : (nst >= 20) ? 3 : (nst >= 10) ? 2 : 1;
        if (m_presc == TD - 1) begin
          m_presc = 0;
          m_tl    = m_tl - 1;
          if (m_tl == 0) begin
            m_gs = 3;
            if (ns > m_high) begin
              m_high = ns;
              m_nh   = 1;
            end
          end
        end else begin
          m_presc = m_presc + 1;
        end
      end
      3: if (st) begin
        m_gs = 1; m_nh = 0;
      end
      default: ;
    endcase
  endtask

  function automatic obs_t model_snap();
    obs_t e;
    e.gs = m_gs[1:0];
    e.sc = m_score[SW-1:0];
    e.hi = m_high[SW-1:0];
    e.st = m_streak[7:0];
    e.mu = m_mult[2:0];
    e.tl = m_tl[6:0];
    e.nh = m_nh[0];
    return e;
  endfunction

  // One clock of stimulus followed by a scoreboard comparison.
  task automatic cycle(input string tag, input bit rst_n, input bit st,
                       input bit [NL-1:0] hit, input bit [NL-1:0] miss);
    obs_t e, o;
    @(negedge clk);
    resetbtn_n = rst_n;
    start_btn  = st;
    hit_pulse  = hit;
    miss_pulse = miss;
    model_step(rst_n, st, hit, miss);
    exp_q.push_back(model_snap());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = '{gs: gamestate, sc: score, hi: high_score, st: streak,
          mu: multiplier, tl: time_left, nh: new_high};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed gs=%b score=%0d high=%0d streak=%0d mult=%0d tl=%0d nh=%b, expected gs=%b score=%0d high=%0d streak=%0d mult=%0d tl=%0d nh=%b",
             tag, o.gs, o.sc, o.hi, o.st, o.mu, o.tl, o.nh,
             e.gs, e.sc, e.hi, e.st, e.mu, e.tl, e.nh);
    end
    $display("%-12s rst_n=%b start=%b hit=%b miss=%b -> gs=%b score=%0d high=%0d streak=%0d mult=%0d tl=%0d nh=%b",
             tag, rst_n, st, hit, miss, gamestate, score, high_score, streak,
             multiplier, time_left, new_high);
  endtask

  // Independent check of a single output against a hand-derived constant.
  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === 32'(exp)) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset for two cycles, then enter PLAY
    cycle("reset", 1'b0, 1'b0, '0, '0);
    cycle("reset", 1'b0, 1'b0, '0, '0);
    check("rst_gs", 32'(gamestate), 1);
    check("rst_tl", 32'(time_left), 3);
    check("rst_mult", 32'(multiplier), 1);
    idle("title", 1);
    cycle("start", 1'b1, 1'b1, '0, '0);
    check("start_gs", 32'(gamestate), 2);
    check("start_score", 32'(score), 0);

    // Round 1: no input, timer runs out; 0 vs 0 is not a new high
    for (int i = 1; i <= 12; i++) begin
      cycle("r1_idle", 1'b1, 1'b0, '0, '0);
      if (i == 4)  check("r1_tl4", 32'(time_left), 2);
      if (i == 8)  check("r1_tl8", 32'(time_left), 1);
      if (i == 11) check("r1_gs11", 32'(gamestate), 2);
    end
    check("r1_tl_end", 32'(time_left), 0);
    check("r1_gs_end", 32'(gamestate), 3);
    check("r1_nh", 32'(new_high), 0);

    // Round 2: ten single hits, then two hits at multiplier 2 -> 140
    cycle("over2title", 1'b1, 1'b1, '0, '0);
    cycle("start", 1'b1, 1'b1, '0, '0);
    for (int i = 0; i < 10; i++) cycle("r2_hit", 1'b1, 1'b0, 4'(1 << (i % 4)), '0);
    check("r2_score100", 32'(score), 100);
    check("r2_mult2", 32'(multiplier), 2);
    cycle("r2_hit2", 1'b1, 1'b0, 4'b0011, '0);
    check("r2_score140", 32'(score), 140);
    check("r2_streak12", 32'(streak), 12);
    idle("r2_idle", 1);
    check("r2_gs_over", 32'(gamestate), 3);
    check("r2_high", 32'(high_score), 140);
    check("r2_nh", 32'(new_high), 1);
    cycle("r2_over_hit", 1'b1, 1'b0, 4'b1111, '0);
    check("r2_frozen", 32'(score), 140);
    cycle("over2title", 1'b1, 1'b1, '0, '0);
    check("r2_nh_clr", 32'(new_high), 0);

    // Round 3: hit and miss in one cycle; start_btn ignored in PLAY
    cycle("start", 1'b1, 1'b1, '0, '0);
    for (int i = 0; i < 6; i++) cycle("r3_hit2", 1'b1, 1'b0, 4'b0011, '0);
    check("r3_streak12", 32'(streak), 12);
    cycle("r3_hitmiss", 1'b1, 1'b0, 4'b0001, 4'b0100);
    check("r3_score160", 32'(score), 160);
    check("r3_streak0", 32'(streak), 0);
    check("r3_mult1", 32'(multiplier), 1);
    cycle("r3_startign", 1'b1, 1'b1, '0, '0);
    idle("r3_idle", 4);
    check("r3_nh", 32'(new_high), 1);

    // Round 4: identical round ties the high score -> no new high
    cycle("over2title", 1'b1, 1'b1, '0, '0);
    cycle("start", 1'b1, 1'b1, '0, '0);
    for (int i = 0; i < 6; i++) cycle("r4_hit2", 1'b1, 1'b0, 4'b0011, '0);
    cycle("r4_hitmiss", 1'b1, 1'b0, 4'b0001, 4'b0100);
    idle("r4_idle", 5);
    check("r4_gs_over", 32'(gamestate), 3);
    check("r4_tie_nh", 32'(new_high), 0);
    check("r4_high", 32'(high_score), 160);

    // Round 5: all lanes every cycle drives score into saturation
    cycle("over2title", 1'b1, 1'b1, '0, '0);
    cycle("start", 1'b1, 1'b1, '0, '0);
    for (int i = 0; i < 12; i++) cycle("r5_all", 1'b1, 1'b0, 4'b1111, '0);
    check("r5_sat", 32'(score), 255);
    check("r5_high", 32'(high_score), 255);

    // Round 6: reset mid-PLAY, then pulses in TITLE are ignored
    cycle("over2title", 1'b1, 1'b1, '0, '0);
    cycle("start", 1'b1, 1'b1, '0, '0);
    for (int i = 0; i < 5; i++) cycle("r6_hit", 1'b1, 1'b0, 4'b1000, '0);
    check("r6_score50", 32'(score), 50);
    check("r6_tl2", 32'(time_left), 2);
    cycle("r6_reset", 1'b0, 1'b0, 4'b0001, '0);
    check("r6_rst_gs", 32'(gamestate), 1);
    check("r6_rst_high", 32'(high_score), 0);
    check("r6_rst_tl", 32'(time_left), 3);
    for (int i = 0; i < 3; i++) cycle("r6_title_hit", 1'b1, 1'b0, 4'b1111, 4'b0010);
    check("r6_title_score", 32'(score), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
- Central game controller for the note-lane blocks.
- Drives the shared `gamestate` bus that every lane consumes.
- Consumes each lane's single-cycle hit and miss pulses, and keeps score, streak, multiplier, round timer and high score for the VGA text/overlay logic.
- Lanes are producers of point pulses; this block is the consumer and the owner of game-phase sequencing.

Parameters:
- NUM_LANES, 4, number of note lanes feeding hit/miss pulses
- SCORE_W, 16, width of score and high_score
- POINTS_PER_HIT, 10, base points per hit before the multiplier
- TICK_DIV, 100000000, clk cycles per one-second timer tick
- ROUND_SECONDS, 60, round length in seconds (max 127)

Ports:
- clk  input  1  system clock
- resetbtn_n  input  1  synchronous active-low reset
- start_btn  input  1  debounced single-cycle start/continue pulse
- hit_pulse  input  NUM_LANES  one-cycle "point scored" pulse per lane
- miss_pulse  input  NUM_LANES  one-cycle "press outside hit zone" pulse per lane
- gamestate  output  2  01 TITLE, 10 PLAY, 11 OVER; 00 never driven
- score  output  SCORE_W  current round score
- high_score  output  SCORE_W  best score since reset
- streak  output  8  consecutive hits without a miss
- multiplier  output  3  current multiplier, 1..4
- time_left  output  7  seconds remaining in the round
- new_high  output  1  high in OVER if this round set a new high score

Behaviour:
- Reset (resetbtn_n low at a clk edge) is synchronous, active-low, and has priority at any time, including mid-round:
  - gamestate=01
  - score, high_score, streak = 0
  - multiplier=1
  - time_left=ROUND_SECONDS
  - new_high=0
  - prescaler=0
- FSM:
  - TITLE: start_btn moves to PLAY.
  - PLAY: timer expiry moves to OVER; start_btn is ignored.
  - OVER: start_btn moves to TITLE.
- On the TITLE->PLAY edge:
  - score=0, streak=0, multiplier=1
  - time_left=ROUND_SECONDS, prescaler=0, new_high=0
  - The first PLAY cycle then counts as prescaler cycle 0.
- Timer (PLAY only):
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - At the wrap cycle, time_left decrements by 1.
  - If time_left was 1, the same edge sets time_left=0 and gamestate=11.
  - The prescaler holds outside PLAY.
- Scoring (PLAY only; pulses outside PLAY are ignored):
  - h = popcount(hit_pulse).
  - score += h*multiplier*POINTS_PER_HIT, using the multiplier registered before this edge.
  - Score saturates at 2^SCORE_W-1.
  - If any miss_pulse bit is set, streak=0 regardless of hits in the same cycle. The hits in that cycle still score.
  - Otherwise streak += h, saturating at 255.
  - Multiplier is registered from the updated streak: <10 gives 1, 10..19 gives 2, 20..29 gives 3, ≥30 gives 4. It takes effect one cycle after the streak update.
  - Latency: score and streak update on the edge following the pulse cycle.
- Hits in the expiry cycle still score. The final score is compared on the PLAY->OVER edge:
  - If final score > high_score, high_score takes the final score and new_high=1.
  - A tie leaves new_high=0.
- OVER: score, streak and time_left are frozen.
- OVER->TITLE: new_high=0. Score is retained for display until the next PLAY entry.

Decomposition:
- Shared package `game_pkg` holds:
  - gamestate encodings TITLE/PLAY/OVER, shared with all lane modules
  - multiplier thresholds 10/20/30
  - streak width
- One sub-module, `round_timer`:
  - contains the prescaler and time_left down-counter
  - inputs: load, enable
  - outputs: time_left and a one-cycle expire pulse
- Popcount and scoring stay inline.

Test Plan (TICK_DIV=4, ROUND_SECONDS=3):
- Reset low for 2 cycles, then high, then start_btn pulse -> gamestate 01 after reset and 10 one cycle after start; score=0, time_left=3.
- In PLAY, 12 cycles with no input -> time_left steps 3,2,1,0 every 4 cycles; gamestate=11 on the same edge time_left reaches 0; high_score unchanged at 0.
- 10 single-lane hits in successive cycles, then hit_pulse=4'b0011 -> score 100 after the 10 hits, multiplier=2, then score 140, streak=12.
- With streak=12, hit_pulse=4'b0001 and miss_pulse=4'b0100 in the same cycle -> score +20, streak=0, multiplier=1 on the following cycle.
- Round ends with score 140 and high_score 0 -> high_score=140, new_high=1. A second round ending at 140 -> new_high=0.
- Reset asserted mid-PLAY with score 50, time_left 2 -> next edge gamestate=01, score=0, high_score=0, time_left=3; hit pulses in TITLE leave score at 0.
